// File: rtl/disp_pkg.sv
// Shared encodings and default sizes for the serial display sequencers.
// Optional build macro: SERIAL_DISP_AUTO_REFRESH_EN (periodic re-send of the last frame).
package disp_pkg;

    localparam int unsigned SEG_DATA_W         = 64;
    localparam int unsigned LED_DATA_W         = 16;
    localparam int unsigned DEF_CLK_DIV        = 8;
    localparam int unsigned DEF_REFRESH_CYCLES = 50_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } disp_state_t;

    // Cycles from busy rising to the done pulse for one frame.
    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clk_div);
        return (2 * data_w + 1) * clk_div;
    endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Modulo-DIV cycle counter with synchronous clear and a wrap pulse.
// Serves as the serial-clock half-period divider and as the refresh timer.
module clk_div_tick
    import disp_pkg::*;
#(
    parameter int unsigned DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_disp_ctrl.sv
// Serial display chain sequencer: MSB-first shift on a divided clock, then latch pulse.
// Optional build macro: SERIAL_DISP_AUTO_REFRESH_EN (periodic re-send of the last frame).
module serial_disp_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DATA_W         = SEG_DATA_W,
    parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
    parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              upd_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sclk_o,
    output logic              sdo_o,
    output logic              pen_o
);

    localparam int unsigned   BW       = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    if (DATA_W < 2 || CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : g_bad_params
    end

    disp_state_t       state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] pend_buf;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] shadow_data;
    logic [BW-1:0]     bit_cnt;
    logic              pending;
    logic              in_idle;
    logic              div_tick;
    logic              auto_start;
    logic              start;

    assign in_idle = (state == IDLE);

    clk_div_tick #(
        .DIV (CLK_DIV)
    ) u_shift_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (in_idle),
        .en   (!in_idle),
        .tick (div_tick)
    );

`ifdef SERIAL_DISP_AUTO_REFRESH_EN
    logic              refresh_tick;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] cur_frame;

    clk_div_tick #(
        .DIV (REFRESH_CYCLES)
    ) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .clr  (!in_idle),
        .en   (in_idle),
        .tick (refresh_tick)
    );

    assign auto_start  = refresh_tick && !pending && !upd_i;
    assign shadow_data = shadow;

    // Shadow only follows frames that were actually latched into the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            cur_frame <= '0;
        end else begin
            if (start) begin
                cur_frame <= load_data;
            end
            if (state == LATCH && div_tick) begin
                shadow <= cur_frame;
            end
        end
    end
`else
    assign auto_start  = 1'b0;
    assign shadow_data = '0;
`endif

    // The done cycle counts as busy for new strobes, giving one clean idle cycle.
    assign start = in_idle && !done_o && (upd_i || pending || auto_start);

    always_comb begin
        load_data = shadow_data;
        if (upd_i) begin
            load_data = data_i;
        end else if (pending) begin
            load_data = pend_buf;
        end
    end

    assign sdo_o = shift_reg[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            sclk_o    <= 1'b0;
            pen_o     <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            pending   <= 1'b0;
            pend_buf  <= '0;
        end else begin
            done_o <= 1'b0;
            if (upd_i && !start) begin
                pending  <= 1'b1;
                pend_buf <= data_i;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= load_data;
                        pending   <= 1'b0;
                        busy_o    <= 1'b1;
                        pen_o     <= 1'b0;
                        sclk_o    <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_tick) begin
                        sclk_o <= 1'b1;
                        state  <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (div_tick) begin
                        sclk_o <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= LATCH;
                        end else begin
                            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + BW'(1);
                            state     <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (div_tick) begin
                        pen_o  <= 1'b1;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_disp_ctrl.sv
// Scoreboard bench for serial_disp_ctrl with an 8-bit chain and CLK_DIV=2.
// Optional build macro: SERIAL_DISP_AUTO_REFRESH_EN selects the refresh scenario.
module tb_serial_disp_ctrl;

    localparam int DW    = 8;
    localparam int CD    = 2;
    localparam int RC    = 100;
    localparam int FRAME = (2 * DW + 1) * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd_i;
    logic [DW-1:0] data_i;
    logic          busy_o;
    logic          done_o;
    logic          sclk_o;
    logic          sdo_o;
    logic          pen_o;

    serial_disp_ctrl #(
        .DATA_W         (DW),
        .CLK_DIV        (CD),
        .REFRESH_CYCLES (RC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .upd_i  (upd_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .sclk_o (sclk_o),
        .sdo_o  (sdo_o),
        .pen_o  (pen_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: rebuild each frame from sdo at sclk rises, compare on done.
    logic          prev_sclk = 1'b0;
    logic          prev_busy = 1'b0;
    logic [DW-1:0] sh = '0;
    int            nbits = 0;
    int            rise_cyc = 0;
    int            frames = 0;
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
    logic [DW-1:0] shadow_m = '0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
            sh    = '0;
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
            shadow_m = '0;
`endif
        end else begin
            if (busy_o && !prev_busy) begin
                rise_cyc = cyc;
                nbits    = 0;
            end
            if (sclk_o && !prev_sclk) begin
                sh = {sh[DW-2:0], sdo_o};
                nbits++;
            end
            if (done_o) begin
                frames++;
                check("frame_bits", nbits, DW);
                check("frame_len", cyc - rise_cyc, FRAME);
                check("pen_at_done", int'(pen_o), 1);
                if (exp_q.size() > 0) begin
                    check("frame_data", int'(sh), int'(exp_q.pop_front()));
                end else begin
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
                    check("refresh_data", int'(sh), int'(shadow_m));
`else
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h expected none", sh);
`endif
                end
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
                shadow_m = sh;
`endif
            end
        end
        prev_sclk = sclk_o;
        prev_busy = busy_o;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_o) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            total++;
            bad++;
            $display("FAIL wait_done: got timeout expected done_o pulse");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int dc;
        int dc2;
        int seen;
        int f0;

        rst    = 1'b1;
        upd_i  = 1'b0;
        data_i = '0;
        tick(3);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_sclk", int'(sclk_o), 0);
        check("rst_sdo", int'(sdo_o), 0);
        check("rst_pen", int'(pen_o), 1);
        rst = 1'b0;
        tick(1);

        // Single frame A5: busy at cycle 1, done at cycle 35.
        t0 = cyc;
        upd_i  = 1'b1;
        data_i = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        upd_i = 1'b0;
        check("a5_busy_c1", int'(busy_o), 1);
        check("a5_pen_low", int'(pen_o), 0);
        check("a5_sdo_msb", int'(sdo_o), 1);
        check("a5_busy_cycle", cyc - t0, 1);
        wait_done(dc);
        check("a5_done_cycle", dc - t0, 35);
        tick(2);

        // Two strobes during a 33 frame: only the last one is shifted next.
        t0 = cyc;
        upd_i  = 1'b1;
        data_i = 8'h33;
        exp_q.push_back(8'h33);
        @(negedge clk);
        upd_i = 1'b0;
        tick(9);
        upd_i  = 1'b1;
        data_i = 8'h0F;
        @(negedge clk);
        upd_i = 1'b0;
        @(negedge clk);
        upd_i  = 1'b1;
        data_i = 8'hF0;
        exp_q.push_back(8'hF0);
        @(negedge clk);
        upd_i = 1'b0;
        f0 = frames;
        wait_done(dc);
        wait_done(dc2);
        check("b2b_gap", dc2 - dc, FRAME + 2);
        tick(60);
        check("ovw_frames", frames - f0, 2);
        check("ovw_idle", int'(busy_o), 0);
        check("ovw_queue", exp_q.size(), 0);

        // Strobe in the done cycle becomes pending; one idle cycle between frames.
        upd_i  = 1'b1;
        data_i = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        upd_i = 1'b0;
        wait_done(dc);
        upd_i  = 1'b1;
        data_i = 8'h81;
        exp_q.push_back(8'h81);
        @(negedge clk);
        upd_i = 1'b0;
        check("gap_pen", int'(pen_o), 1);
        check("gap_busy", int'(busy_o), 0);
        @(negedge clk);
        check("gap_busy_rise", int'(busy_o), 1);
        check("gap_pen_low", int'(pen_o), 0);
        check("gap_rise_cycle", cyc - dc, 2);
        wait_done(dc);
        tick(5);

        // Reset in cycle 20 of a frame abandons it.
        t0 = cyc;
        upd_i  = 1'b1;
        data_i = 8'h77;
        @(negedge clk);
        upd_i = 1'b0;
        tick(19);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", int'(busy_o), 0);
        check("mid_rst_pen", int'(pen_o), 1);
        check("mid_rst_sclk", int'(sclk_o), 0);
        check("mid_rst_sdo", int'(sdo_o), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) seen = 1;
        end
        check("mid_rst_no_done", seen, 0);
        t0 = cyc;
        upd_i  = 1'b1;
        data_i = 8'hC3;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        upd_i = 1'b0;
        wait_done(dc);
        check("c3_done_cycle", dc - t0, 35);
        tick(3);

`ifdef SERIAL_DISP_AUTO_REFRESH_EN
        upd_i  = 1'b1;
        data_i = 8'h5A;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        upd_i = 1'b0;
        wait_done(dc);
        exp_q.push_back(8'h5A);
        seen = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_o) begin
                seen = cyc - dc;
                break;
            end
        end
        check("refresh_start", seen, RC);
        wait_done(dc);
`else
        upd_i  = 1'b1;
        data_i = 8'h5A;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        upd_i = 1'b0;
        wait_done(dc);
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy_o) seen = 1;
        end
        check("no_auto_refresh", seen, 0);
`endif
        tick(2);
        check("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
